melody_sequencer: RTL and testbench

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

---
 rtl/melody_sequencer_pkg.sv | 32 +++
 rtl/melody_sequencer_tempo_tick.sv | 27 ++
 rtl/melody_sequencer.sv | 169 ++++++++++++++++
 tb/tb_melody_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/melody_sequencer_pkg.sv
// Shared types and constants for the melody sequencer: pitch codes, FSM states, note-table entry layout.
package melody_sequencer_pkg;

    localparam int unsigned PITCH_W = 4;
    localparam int unsigned DUR_W   = 4;
    localparam int unsigned ENTRY_W = DUR_W + PITCH_W;
    localparam int unsigned ADDR_W  = 5;

    localparam logic [PITCH_W-1:0] PITCH_A     = 4'd0;
    localparam logic [PITCH_W-1:0] PITCH_DHIGH = 4'd1;
    localparam logic [PITCH_W-1:0] PITCH_C     = 4'd2;
    localparam logic [PITCH_W-1:0] PITCH_B     = 4'd3;
    localparam logic [PITCH_W-1:0] PITCH_G     = 4'd4;
    localparam logic [PITCH_W-1:0] PITCH_FIS   = 4'd5;
    localparam logic [PITCH_W-1:0] PITCH_E     = 4'd6;
    localparam logic [PITCH_W-1:0] PITCH_D     = 4'd7;
    localparam logic [PITCH_W-1:0] PITCH_REST  = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_PLAY,
        ST_GAP
    } state_t;

    typedef struct packed {
        logic [DUR_W-1:0]   duration;
        logic [PITCH_W-1:0] pitch;
    } note_entry_t;

endpackage

// File: rtl/melody_sequencer_tempo_tick.sv
// Eighth-note tempo divider: one-cycle tick every EIGHTH_CYCLES enabled cycles, restarted on note load.
module melody_sequencer_tempo_tick #(
    parameter int unsigned EIGHTH_CYCLES = 3000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick_c
);

    localparam int unsigned CNT_W = (EIGHTH_CYCLES > 1) ? $clog2(EIGHTH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EIGHTH_CYCLES - 1);

    logic [CNT_W-1:0] sub_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sub_cnt <= '0;
        end else if (enable) begin
            sub_cnt <= (sub_cnt == CNT_LAST) ? '0 : sub_cnt + CNT_W'(1);
        end
    end

    assign tick_c = enable && (sub_cnt == CNT_LAST);

endmodule

// File: rtl/melody_sequencer.sv
// Note-table melody sequencer driving a pitch code and mute to the sine generator.
// Define MELODY_GAP_EN to insert GAP_CYCLES of silence between notes (otherwise legato).
module melody_sequencer
    import melody_sequencer_pkg::*;
#(
    parameter int unsigned EIGHTH_CYCLES = 3000000,
    parameter int unsigned SONG_LEN      = 20,
    parameter int unsigned GAP_CYCLES    = 120000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               loop,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [ENTRY_W-1:0] rom_data,
    output logic [PITCH_W-1:0] frequency,
    output logic               mute,
    output logic               busy,
    output logic               note_strobe,
    output logic               done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SONG_LEN - 1);

`ifdef MELODY_GAP_EN
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    logic [GAP_W-1:0] gap_cnt;
`endif

    state_t             state, state_d;
    logic [ADDR_W-1:0]  index, index_d;
    logic [DUR_W-1:0]   dur, unit_cnt;
    logic [PITCH_W-1:0] frequency_d;
    logic               mute_d, busy_d, note_strobe_d, done_d;
    logic               tick_c, play_end_c, advance_c, song_end_c;
    note_entry_t        entry;

    assign entry      = note_entry_t'(rom_data);
    assign rom_addr   = index;
    assign play_end_c = (state == ST_PLAY) && tick_c && (unit_cnt == dur - DUR_W'(1));
    // In LOAD an advance only happens for the end marker, which always ends the song
    assign song_end_c = (index == LAST_IDX) || (state == ST_LOAD);

    melody_sequencer_tempo_tick #(
        .EIGHTH_CYCLES(EIGHTH_CYCLES)
    ) tempo_tick (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == ST_LOAD),
        .enable (state == ST_PLAY),
        .tick_c (tick_c)
    );

    // State register (index travels with the state)
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            index <= '0;
        end else begin
            state <= state_d;
            index <= index_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state;
        index_d   = index;
        advance_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_FETCH;
                    index_d = '0;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                if (entry.duration == '0) begin
                    advance_c = 1'b1;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (play_end_c) begin
`ifdef MELODY_GAP_EN
                    state_d = ST_GAP;
`else
                    advance_c = 1'b1;
`endif
                end
            end
`ifdef MELODY_GAP_EN
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    advance_c = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        if (advance_c) begin
            if (!song_end_c) begin
                index_d = index + ADDR_W'(1);
                state_d = ST_FETCH;
            end else if (loop) begin
                index_d = '0;
                state_d = ST_FETCH;
            end else begin
                state_d = ST_IDLE;
            end
        end
        if (stop && (state != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    // Output logic (next values of the registered outputs)
    always_comb begin
        frequency_d   = frequency;
        mute_d        = mute;
        note_strobe_d = 1'b0;
        busy_d        = (state_d != ST_IDLE);
        done_d        = advance_c && song_end_c && !loop && !stop;
        if ((state == ST_LOAD) && (state_d == ST_PLAY)) begin
            frequency_d   = entry.pitch;
            mute_d        = (entry.pitch == PITCH_REST);
            note_strobe_d = 1'b1;
        end
        if ((state_d == ST_IDLE) || (state_d == ST_GAP)) begin
            mute_d = 1'b1;
        end
    end

    // Output registers and note counters
    always_ff @(posedge clk) begin
        if (reset) begin
            frequency   <= '0;
            mute        <= 1'b1;
            busy        <= 1'b0;
            note_strobe <= 1'b0;
            done        <= 1'b0;
            dur         <= '0;
            unit_cnt    <= '0;
`ifdef MELODY_GAP_EN
            gap_cnt     <= '0;
`endif
        end else begin
            frequency   <= frequency_d;
            mute        <= mute_d;
            busy        <= busy_d;
            note_strobe <= note_strobe_d;
            done        <= done_d;
            if (state == ST_LOAD) begin
                dur      <= entry.duration;
                unit_cnt <= '0;
            end else if ((state == ST_PLAY) && tick_c) begin
                unit_cnt <= unit_cnt + DUR_W'(1);
            end
`ifdef MELODY_GAP_EN
            gap_cnt <= (state == ST_GAP) ? gap_cnt + GAP_W'(1) : '0;
`endif
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed self-checking bench for melody_sequencer (small tempo, 3-entry table, synchronous ROM model).
module tb_melody_sequencer;

    localparam int unsigned EIGHTH = 4;
    localparam int unsigned SLEN   = 3;
    localparam int unsigned GAPC   = 2;
`ifdef MELODY_GAP_EN
    localparam int G = GAPC;
`else
    localparam int G = 0;
`endif

    logic       clk = 1'b0;
    logic       reset, start, stop, loop;
    logic [4:0] rom_addr;
    logic [7:0] rom_data;
    logic [3:0] frequency;
    logic       mute, busy, note_strobe, done;
    logic [7:0] rom [0:31];

    int n_checks = 0;
    int n_fail   = 0;

    melody_sequencer #(
        .EIGHTH_CYCLES(EIGHTH),
        .SONG_LEN     (SLEN),
        .GAP_CYCLES   (GAPC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .loop       (loop),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .frequency  (frequency),
        .mute       (mute),
        .busy       (busy),
        .note_strobe(note_strobe),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Step until note_strobe (want_done=0) or done (want_done=1); n=-1 on timeout
    task automatic run_until(input bit want_done, output int n, output bit saw_other);
        n = -1;
        saw_other = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (want_done ? done : note_strobe) begin
                n = i;
                break;
            end
            if (want_done ? note_strobe : done) saw_other = 1'b1;
        end
    endtask

    initial begin
        int n;
        bit other;
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        rom[0] = 8'h27;
        rom[1] = 8'h1F;
        rom[2] = 8'h30;
        reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
        tick();
        tick();
        check_eq("rst_freq", 32'(frequency), 0);
        check_eq("rst_mute", 32'(mute), 1);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_strobe", 32'(note_strobe), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_addr", 32'(rom_addr), 0);
        reset = 1'b0;
        tick();
        check_eq("idle_busy", 32'(busy), 0);

        // Full song, no loop
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("start_busy", 32'(busy), 1);
        check_eq("fetch_addr", 32'(rom_addr), 0);
        check_eq("fetch_strobe", 32'(note_strobe), 0);
        tick();
        check_eq("load_strobe", 32'(note_strobe), 0);
        tick();
        check_eq("n0_strobe", 32'(note_strobe), 1);
        check_eq("n0_freq", 32'(frequency), 7);
        check_eq("n0_mute", 32'(mute), 0);
        for (int k = 1; k < 8; k++) begin
            start = (k == 3);
            tick();
            start = 1'b0;
            check_eq("n0_hold_mute", 32'(mute), 0);
            check_eq("n0_hold_freq", 32'(frequency), 7);
            check_eq("n0_hold_strobe", 32'(note_strobe), 0);
        end
        tick();
        check_eq("after_n0_mute", 32'(mute), (G != 0) ? 1 : 0);
        run_until(1'b0, n, other);
        check_eq("n1_delay", 32'(n), 32'(2 + G));
        check_eq("n1_freq", 32'(frequency), 15);
        check_eq("n1_mute", 32'(mute), 1);
        check_eq("n1_addr", 32'(rom_addr), 1);
        run_until(1'b0, n, other);
        check_eq("n2_delay", 32'(n), 32'(6 + G));
        check_eq("n2_freq", 32'(frequency), 0);
        check_eq("n2_mute", 32'(mute), 0);
        check_eq("n2_addr", 32'(rom_addr), 2);
        run_until(1'b1, n, other);
        check_eq("end_delay", 32'(n), 32'(12 + G));
        check_eq("end_no_strobe", 32'(other), 0);
        check_eq("end_busy", 32'(busy), 0);
        check_eq("end_mute", 32'(mute), 1);
        tick();
        check_eq("done_pulse", 32'(done), 0);

        // Loop back to entry 0, then stop mid-note
        loop = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until(1'b0, n, other);
        check_eq("lp_n0_delay", 32'(n), 2);
        run_until(1'b0, n, other);
        check_eq("lp_n1_delay", 32'(n), 32'(10 + G));
        run_until(1'b0, n, other);
        check_eq("lp_n2_delay", 32'(n), 32'(6 + G));
        run_until(1'b0, n, other);
        check_eq("lp_wrap_delay", 32'(n), 32'(14 + G));
        check_eq("lp_no_done", 32'(other), 0);
        check_eq("lp_wrap_addr", 32'(rom_addr), 0);
        check_eq("lp_wrap_freq", 32'(frequency), 7);
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("stop_busy", 32'(busy), 0);
        check_eq("stop_mute", 32'(mute), 1);
        check_eq("stop_done", 32'(done), 0);
        loop = 1'b0;
        run_until(1'b1, n, other);
        check_eq("stop_never_done", 32'(n), 32'(-1));

        // start and stop together in IDLE
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        check_eq("ss_busy0", 32'(busy), 0);
        tick();
        check_eq("ss_busy1", 32'(busy), 0);

        // End marker (duration 0) in entry 1
        rom[1] = 8'h03;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until(1'b0, n, other);
        check_eq("em_n0_delay", 32'(n), 2);
        run_until(1'b1, n, other);
        check_eq("em_done_delay", 32'(n), 32'(10 + G));
        check_eq("em_no_strobe", 32'(other), 0);
        check_eq("em_busy", 32'(busy), 0);
        check_eq("em_mute", 32'(mute), 1);

        // Reset in the middle of the rest note, then replay
        rom[1] = 8'h1F;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until(1'b0, n, other);
        run_until(1'b0, n, other);
        check_eq("mr_pre_addr", 32'(rom_addr), 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mr_freq", 32'(frequency), 0);
        check_eq("mr_mute", 32'(mute), 1);
        check_eq("mr_busy", 32'(busy), 0);
        check_eq("mr_addr", 32'(rom_addr), 0);
        check_eq("mr_strobe", 32'(note_strobe), 0);
        check_eq("mr_done", 32'(done), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("mr_restart_busy", 32'(busy), 1);
        run_until(1'b0, n, other);
        check_eq("mr_restart_delay", 32'(n), 2);
        check_eq("mr_restart_freq", 32'(frequency), 7);
        check_eq("mr_restart_addr", 32'(rom_addr), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
